onehot_index_stage: RTL and testbench
=====================================

// Module: onehot_index_stage
// PURPOSE
//  Downstream stage of the one-hot checker. Consumes each data word together with the
//  checker's 1-bit onehot verdict, and encodes valid one-hot words to a binary bit index.
//  Flags invalid words and cross-checks the verdict with an internal popcount.
//  Keeps a saturating error count. Fully pipelined valid/ready stream, 1 word/cycle.
// PARAMETERS
//  DATA_WIDTH  6  width of in_data; must match the checker's DATA_WIDTH (>=2)
//  CNT_WIDTH   8  width of err_count
//  IDX_W       $clog2(DATA_WIDTH)  localparam, width of out_index (3 for default)
// PORTS
//  clk         in   1           rising-edge clock
//  rst_n       in   1           async active-low reset
//  in_valid    in   1           upstream word valid
//  in_ready    out  1           stage can accept a word
//  in_data     in   DATA_WIDTH  word as presented to the checker (din)
//  in_onehot   in   1           checker verdict for in_data (same cycle)
//  out_valid   out  1           out_index/out_err valid
//  out_ready   in   1           downstream accepts
//  out_index   out  IDX_W       bit position of the single set bit; 0 when out_err=1
//  out_err     out  1           word was not one-hot, or the verdict disagreed
//  clr_count   in   1           sync clear of err_count
//  err_count   out  CNT_WIDTH   count of transferred words with out_err=1, saturating
//  mismatch    out  1           sticky: in_onehot != internal popcount==1 on an accepted word
// BEHAVIOUR
//  Reset (async assert, sync release): out_valid=0, out_index=0, out_err=0, err_count=0,
//   mismatch=0, in_ready=1, skid entry empty.
//  Handshake: an input transfer happens when in_valid&in_ready.
//   An output transfer happens when out_valid&out_ready.
//   out_* hold stable while out_valid&~out_ready.
//  Buffer: output register plus 1 skid register. States:
//   EMPTY (out_valid=0), ONE (output reg full), TWO (output+skid full).
//   EMPTY --in--> ONE.
//   ONE --in&~out--> TWO.
//   ONE --out&~in--> EMPTY.
//   ONE with in&out stays ONE.
//   TWO --out--> ONE (skid moves to output).
//   in_ready is registered, = ~(state==TWO).
//   No combinational path from out_ready to in_ready.
//  Latency: word accepted in cycle N appears on out_* in cycle N+1 when the stage was EMPTY
//   or ONE with out transfer. Order is always preserved; no loss, no duplication.
//  Encode (at input acceptance): internal ok = (popcount(in_data)==1).
//   Verdict = in_onehot. err = ~in_onehot | (in_onehot != ok).
//   index = position of the set bit if ~err, else 0.
//   in_data==0 gives err=1.
//   MSB (bit DATA_WIDTH-1) gives index DATA_WIDTH-1.
//  mismatch: set on any accepted word with in_onehot != ok; cleared only by reset.
//  err_count: +1 on each output transfer with out_err=1; saturates at all-ones, no wrap.
//   clr_count has priority: clr_count and an increment in the same cycle gives 0.
//  Reset asserted mid-stream: all buffered words are discarded; outputs return to reset values.
//  in_valid with in_ready=0: no state change; upstream must hold its word.
// TESTING
//  1 Stream in_data 1,2,3,5,32,33 with correct in_onehot, out_ready=1
//    -> out_index 0,1,-,-,5,- ; out_err 0,0,1,1,0,1.
//    Each arrives 1 cycle after accept; err_count=3, mismatch=0.
//  2 Stream 8 words (1,2,4,8,16,32,1,2), out_ready=0 for cycles 2-5
//    -> in_ready falls after 2 accepts while stalled; output order is intact.
//    Indices are 0,1,2,3,4,5,0,1.
//  3 in_data=4 with in_onehot=0 -> out_err=1, out_index=0, mismatch=1 (stays 1).
//    in_data=3 with in_onehot=1 -> out_err=1.
//  4 CNT_WIDTH=2: send 5 error words -> err_count=3 (saturated).
//    clr_count with a concurrent error transfer -> err_count=0.
//  5 rst_n pulsed low while in state TWO -> out_valid=0 and in_ready=1 immediately.
//    err_count=0; first word after release appears 1 cycle after accept.

Source files
------------

// File: rtl/onehot_index_if.sv
// Valid/ready stream bundle for the one-hot index stage: checked word in, encoded index out.
interface onehot_index_if #(
  parameter int DATA_WIDTH = 6,
  parameter int IDX_W      = $clog2(DATA_WIDTH)
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_onehot;
  logic                  out_valid;
  logic                  out_ready;
  logic [IDX_W-1:0]      out_index;
  logic                  out_err;

  modport master (
    output in_valid, in_data, in_onehot, out_ready,
    input  in_ready, out_valid, out_index, out_err
  );

  modport slave (
    input  in_valid, in_data, in_onehot, out_ready,
    output in_ready, out_valid, out_index, out_err
  );
endinterface

// File: rtl/onehot_index_stage.sv
// Encodes checked one-hot words to a bit index, cross-checks the upstream verdict,
// and counts error words; output register plus one skid entry, 1 word/cycle.
module onehot_index_stage #(
  parameter int DATA_WIDTH = 6,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  onehot_index_if.slave        s,
  input  logic                 clr_count,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic                 mismatch
);
  localparam int IDX_W = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t           state, state_nxt;
  logic             in_ready_q;
  logic [IDX_W-1:0] out_index_q, skid_index;
  logic             out_err_q, skid_err;
  logic             in_xfer, out_xfer;
  logic             load_out, load_skid, skid_to_out;

  logic [IDX_W:0]   pc;
  logic [IDX_W-1:0] idx, enc_idx;
  logic             ok, enc_err;

  assign s.in_ready  = in_ready_q;
  assign s.out_valid = (state != EMPTY);
  assign s.out_index = out_index_q;
  assign s.out_err   = out_err_q;

  assign in_xfer  = s.in_valid & in_ready_q;
  assign out_xfer = s.out_valid & s.out_ready;

  // popcount and bit position in one pass; index only trusted when exactly one bit set
  always_comb begin
    pc  = '0;
    idx = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      pc = pc + {{IDX_W{1'b0}}, s.in_data[i]};
      if (s.in_data[i]) idx = IDX_W'(i);
    end
    ok      = (pc == (IDX_W+1)'(1));
    enc_err = ~s.in_onehot | (s.in_onehot != ok);
    enc_idx = enc_err ? '0 : idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    load_out    = 1'b0;
    load_skid   = 1'b0;
    skid_to_out = 1'b0;
    case (state)
      EMPTY: if (in_xfer) begin
        state_nxt = ONE;
        load_out  = 1'b1;
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          load_out = 1'b1;
        end else if (in_xfer) begin
          state_nxt = TWO;
          load_skid = 1'b1;
        end else if (out_xfer) begin
          state_nxt = EMPTY;
        end
      end
      TWO: if (out_xfer) begin
        state_nxt   = ONE;
        skid_to_out = 1'b1;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // in_ready comes from a flop so out_ready never reaches it combinationally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b1;
      out_index_q <= '0;
      out_err_q   <= 1'b0;
      skid_index  <= '0;
      skid_err    <= 1'b0;
    end else begin
      in_ready_q <= (state_nxt != TWO);
      if (load_out) begin
        out_index_q <= enc_idx;
        out_err_q   <= enc_err;
      end else if (skid_to_out) begin
        out_index_q <= skid_index;
        out_err_q   <= skid_err;
      end
      if (load_skid) begin
        skid_index <= enc_idx;
        skid_err   <= enc_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
      mismatch  <= 1'b0;
    end else begin
      if (clr_count)
        err_count <= '0;
      else if (out_xfer && out_err_q && (err_count != '1))
        err_count <= err_count + 1'b1;
      if (in_xfer && (s.in_onehot != ok))
        mismatch <= 1'b1;
    end
  end
endmodule

// File: tb/tb_onehot_index_stage.sv
// Bench for onehot_index_stage: queue-based reference model plus directed scenarios.
module tb_onehot_index_stage;
  localparam int DW  = 6;
  localparam int IW  = $clog2(DW);
  localparam int CW  = 8;
  localparam int CW2 = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr_count = 1'b0;
  logic [CW-1:0]  err_count;
  logic [CW2-1:0] err_count2;
  logic mismatch, mismatch2;

  always #5 clk = ~clk;

  onehot_index_if #(.DATA_WIDTH(DW)) a ();
  onehot_index_if #(.DATA_WIDTH(DW)) b ();

  assign b.in_valid  = a.in_valid;
  assign b.in_data   = a.in_data;
  assign b.in_onehot = a.in_onehot;
  assign b.out_ready = a.out_ready;

  onehot_index_stage #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .s(a), .clr_count(clr_count),
    .err_count(err_count), .mismatch(mismatch)
  );

  onehot_index_stage #(.DATA_WIDTH(DW), .CNT_WIDTH(CW2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .s(b), .clr_count(clr_count),
    .err_count(err_count2), .mismatch(mismatch2)
  );

  int checks = 0;
  int errors = 0;

  typedef struct { logic [IW-1:0] idx; logic err; } exp_t;
  exp_t q[$];
  logic [IW-1:0] seen[$];
  int cnt = 0, cnt2 = 0;
  bit mm = 0;

  function automatic exp_t model(logic [DW-1:0] d, logic oh);
    exp_t e;
    bit ok = ($countones(d) == 1);
    e.err = !oh || (oh != ok);
    e.idx = '0;
    if (!e.err)
      for (int i = 0; i < DW; i++) if (d == (DW'(1) << i)) e.idx = IW'(i);
    return e;
  endfunction

  // scoreboard: outputs compared against model state, then model advances on the same edge
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete(); cnt = 0; cnt2 = 0; mm = 0;
      checks++;
      if (a.out_valid !== 1'b0 || a.in_ready !== 1'b1 || err_count !== '0 || mismatch !== 1'b0 || b.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold out_valid=%b in_ready=%b err_count=%0d mismatch=%b expected 0/1/0/0", a.out_valid, a.in_ready, err_count, mismatch);
      end
    end else begin
      bit ox, ix;
      exp_t e;
      checks++;
      if (a.out_valid !== (q.size() > 0) || a.in_ready !== (q.size() < 2) || b.out_valid !== (q.size() > 0)) begin
        errors++;
        $display("FAIL flow out_valid=%b in_ready=%b expected %b/%b", a.out_valid, a.in_ready, q.size() > 0, q.size() < 2);
      end
      if (q.size() > 0) begin
        checks++;
        if (a.out_index !== q[0].idx || a.out_err !== q[0].err || b.out_index !== q[0].idx || b.out_err !== q[0].err) begin
          errors++;
          $display("FAIL data index=%0d err=%b expected %0d/%b", a.out_index, a.out_err, q[0].idx, q[0].err);
        end
      end
      checks++;
      if (err_count !== CW'(cnt) || err_count2 !== CW2'(cnt2) || mismatch !== mm || mismatch2 !== mm) begin
        errors++;
        $display("FAIL status err_count=%0d/%0d mismatch=%b expected %0d/%0d/%b", err_count, err_count2, mismatch, cnt, cnt2, mm);
      end
      ox = (q.size() > 0) && (a.out_ready === 1'b1);
      ix = (a.in_valid === 1'b1) && (q.size() < 2);
      if (clr_count) begin
        cnt = 0; cnt2 = 0;
      end else if (ox && q[0].err) begin
        if (cnt < (1 << CW) - 1) cnt++;
        if (cnt2 < (1 << CW2) - 1) cnt2++;
      end
      if (ox) begin
        seen.push_back(q[0].idx);
        void'(q.pop_front());
      end
      if (ix) begin
        e = model(a.in_data, a.in_onehot);
        q.push_back(e);
        if (a.in_onehot != ($countones(a.in_data) == 1)) mm = 1;
      end
    end
  end

  task automatic cycle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(logic [DW-1:0] d, logic oh);
    bit acc = 0;
    a.in_valid = 1'b1; a.in_data = d; a.in_onehot = oh;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = a.in_ready;
      @(posedge clk); #1;
    end
    a.in_valid = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout data=%0d in_ready=%b expected 1", d, a.in_ready);
    end
  endtask

  task automatic test_reset;
    checks++;
    if (a.out_valid !== 1'b0 || a.in_ready !== 1'b1 || a.out_index !== '0 || a.out_err !== 1'b0 || err_count !== '0 || mismatch !== 1'b0) begin
      errors++;
      $display("FAIL reset_state valid=%b ready=%b index=%0d err=%b cnt=%0d mm=%b expected 0/1/0/0/0/0",
               a.out_valid, a.in_ready, a.out_index, a.out_err, err_count, mismatch);
    end
    rst_n = 1'b1;
    cycle(2);
    checks++;
    if (a.out_valid !== 1'b0 || a.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL after_release valid=%b ready=%b expected 0/1", a.out_valid, a.in_ready);
    end
  endtask

  task automatic test_stream;
    logic [DW-1:0] w[6]  = '{1, 2, 3, 5, 32, 33};
    logic [IW-1:0] ei[6] = '{0, 1, 0, 0, 5, 0};
    logic          ee[6] = '{0, 0, 1, 1, 0, 1};
    a.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(w[i], $countones(w[i]) == 1);
      checks++;
      if (a.out_valid !== 1'b1 || a.out_index !== ei[i] || a.out_err !== ee[i]) begin
        errors++;
        $display("FAIL stream_%0d valid=%b index=%0d err=%b expected 1/%0d/%b", i, a.out_valid, a.out_index, a.out_err, ei[i], ee[i]);
      end
    end
    cycle(3);
    checks++;
    if (err_count !== CW'(3) || mismatch !== 1'b0) begin
      errors++;
      $display("FAIL stream_status err_count=%0d mismatch=%b expected 3/0", err_count, mismatch);
    end
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] w[8]  = '{1, 2, 4, 8, 16, 32, 1, 2};
    logic [IW-1:0] ei[8] = '{0, 1, 2, 3, 4, 5, 0, 1};
    bit saw_low = 0;
    seen.delete();
    a.out_ready = 1'b1;
    fork
      for (int i = 0; i < 8; i++) send(w[i], 1'b1);
      begin
        cycle(1);
        a.out_ready = 1'b0;
        repeat (4) begin
          @(negedge clk);
          if (a.in_ready === 1'b0) saw_low = 1;
          @(posedge clk);
        end
        #1 a.out_ready = 1'b1;
      end
    join
    cycle(4);
    checks++;
    if (saw_low !== 1'b1) begin
      errors++;
      $display("FAIL stall_ready in_ready_low_seen=%b expected 1", saw_low);
    end
    checks++;
    if (seen.size() != 8) begin
      errors++;
      $display("FAIL stall_count got %0d words expected 8", seen.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (seen[i] !== ei[i]) begin
          errors++;
          $display("FAIL stall_order_%0d index=%0d expected %0d", i, seen[i], ei[i]);
        end
      end
    end
  endtask

  task automatic test_verdict;
    a.out_ready = 1'b1;
    send(4, 1'b0);
    checks++;
    if (a.out_err !== 1'b1 || a.out_index !== '0 || mismatch !== 1'b1) begin
      errors++;
      $display("FAIL verdict_flip err=%b index=%0d mismatch=%b expected 1/0/1", a.out_err, a.out_index, mismatch);
    end
    send(3, 1'b1);
    checks++;
    if (a.out_err !== 1'b1 || a.out_index !== '0) begin
      errors++;
      $display("FAIL verdict_twobit err=%b index=%0d expected 1/0", a.out_err, a.out_index);
    end
    cycle(3);
    checks++;
    if (mismatch !== 1'b1) begin
      errors++;
      $display("FAIL mismatch_sticky mismatch=%b expected 1", mismatch);
    end
  endtask

  task automatic test_saturate;
    a.out_ready = 1'b1;
    clr_count = 1'b1; cycle(1); clr_count = 1'b0;
    checks++;
    if (err_count !== '0 || err_count2 !== '0) begin
      errors++;
      $display("FAIL clr err_count=%0d/%0d expected 0/0", err_count, err_count2);
    end
    for (int i = 0; i < 5; i++) send(0, 1'b0);
    cycle(2);
    checks++;
    if (err_count2 !== CW2'(3) || err_count !== CW'(5)) begin
      errors++;
      $display("FAIL saturate err_count2=%0d err_count=%0d expected 3/5", err_count2, err_count);
    end
    a.out_ready = 1'b0;
    send(0, 1'b0);
    clr_count = 1'b1; a.out_ready = 1'b1;
    cycle(1);
    clr_count = 1'b0;
    checks++;
    if (err_count !== '0 || err_count2 !== '0) begin
      errors++;
      $display("FAIL clr_priority err_count=%0d/%0d expected 0/0", err_count, err_count2);
    end
  endtask

  task automatic test_random;
    bit acc = 1;
    for (int c = 0; c < 400; c++) begin
      if (acc || !a.in_valid) begin
        a.in_valid = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 1)) a.in_data = DW'(1) << $urandom_range(0, DW - 1);
        else                      a.in_data = DW'($urandom);
        a.in_onehot = ($countones(a.in_data) == 1);
        if ($urandom_range(0, 9) == 0) a.in_onehot = ~a.in_onehot;
      end
      a.out_ready = ($urandom_range(0, 2) != 0);
      clr_count   = ($urandom_range(0, 19) == 0);
      @(negedge clk);
      acc = a.in_valid && a.in_ready;
      @(posedge clk); #1;
    end
    a.in_valid = 1'b0; clr_count = 1'b0; a.out_ready = 1'b1;
    cycle(4);
  endtask

  task automatic test_reset_mid;
    a.out_ready = 1'b0;
    send(1, 1'b1);
    send(2, 1'b1);
    checks++;
    if (a.in_ready !== 1'b0 || a.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL full_state in_ready=%b out_valid=%b expected 0/1", a.in_ready, a.out_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (a.out_valid !== 1'b0 || a.in_ready !== 1'b1 || err_count !== '0) begin
      errors++;
      $display("FAIL mid_reset out_valid=%b in_ready=%b err_count=%0d expected 0/1/0", a.out_valid, a.in_ready, err_count);
    end
    cycle(2);
    rst_n = 1'b1;
    a.out_ready = 1'b1;
    cycle(1);
    send(16, 1'b1);
    checks++;
    if (a.out_valid !== 1'b1 || a.out_index !== IW'(4) || a.out_err !== 1'b0) begin
      errors++;
      $display("FAIL post_reset valid=%b index=%0d err=%b expected 1/4/0", a.out_valid, a.out_index, a.out_err);
    end
    cycle(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    a.in_valid = 1'b0; a.in_data = '0; a.in_onehot = 1'b0; a.out_ready = 1'b0;
    cycle(3);
    test_reset();
    test_stream();
    test_back_to_back();
    test_verdict();
    test_saturate();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
